// File: rtl/bcd_stopwatch_counter_if.sv
// Command and display bundle of the BCD stopwatch; the optional LAP input
// appears only when LAP_HOLD_EN is defined.
interface bcd_stopwatch_counter_if;
   logic       START_STOP;
   logic       CLEAR;
   logic [3:0] DIGIT0;
   logic [3:0] DIGIT1;
   logic       RUNNING;
   logic       WRAP;
`ifdef LAP_HOLD_EN
   logic       LAP;

   modport master (output START_STOP, CLEAR, LAP,
                   input  DIGIT0, DIGIT1, RUNNING, WRAP);
   modport slave  (input  START_STOP, CLEAR, LAP,
                   output DIGIT0, DIGIT1, RUNNING, WRAP);
`else
   modport master (output START_STOP, CLEAR,
                   input  DIGIT0, DIGIT1, RUNNING, WRAP);
   modport slave  (input  START_STOP, CLEAR,
                   output DIGIT0, DIGIT1, RUNNING, WRAP);
`endif
endinterface

// File: rtl/bcd_stopwatch_counter.sv
// Two-digit BCD stopwatch (00..99) with IDLE/RUN/PAUSE control and a TICK_DIV prescaler.
// Optional lap-hold display snapshot is enabled by defining LAP_HOLD_EN.
module bcd_stopwatch_counter #(
   parameter logic [31:0] TICK_DIV = 32'd50000000
) (
   input  logic                    CLOCK_50,
   input  logic                    RESET,
   bcd_stopwatch_counter_if.slave  bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;

   localparam logic [31:0] TICK_LAST = TICK_DIV - 32'd1;

   state_t      state_r;
   state_t      state_nx_s;
   logic        running_nx_s;
   logic        running_r;
   logic        ss_meta_r;
   logic        ss_sync_r;
   logic        ss_prev_r;
   logic        cmd_s;
   logic        tick_s;
   logic [31:0] pre_r;
   logic [3:0]  d0_r;
   logic [3:0]  d1_r;
   logic        wrap_r;

   // START_STOP synchronizer and previous-value register for rise detection
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         ss_meta_r <= 1'b0;
         ss_sync_r <= 1'b0;
         ss_prev_r <= 1'b0;
      end else begin
         ss_meta_r <= bus.START_STOP;
         ss_sync_r <= ss_meta_r;
         ss_prev_r <= ss_sync_r;
      end
   end

   assign cmd_s  = ss_sync_r & ~ss_prev_r;
   assign tick_s = (state_r == RUN) && (pre_r == TICK_LAST);

   // State register; RUNNING is registered from the next state so it tracks state_r exactly
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         state_r   <= IDLE;
         running_r <= 1'b0;
      end else begin
         state_r   <= state_nx_s;
         running_r <= running_nx_s;
      end
   end

   // Next-state decode: CLEAR overrides any same-cycle command
   always_comb begin
      state_nx_s = state_r;
      if (bus.CLEAR) begin
         state_nx_s = IDLE;
      end else if (cmd_s) begin
         case (state_r)
            IDLE:    state_nx_s = RUN;
            RUN:     state_nx_s = PAUSE;
            PAUSE:   state_nx_s = RUN;
            default: state_nx_s = IDLE;
         endcase
      end else begin
         state_nx_s = state_r;
      end
   end

   // Output decode of the next state
   always_comb begin
      running_nx_s = 1'b0;
      if (state_nx_s == RUN) begin
         running_nx_s = 1'b1;
      end else begin
         running_nx_s = 1'b0;
      end
   end

   // Prescaler: counts in RUN, holds in PAUSE, zero in IDLE
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         pre_r <= 32'd0;
      end else if (bus.CLEAR) begin
         pre_r <= 32'd0;
      end else if (state_r == RUN) begin
         if (tick_s) begin
            pre_r <= 32'd0;
         end else begin
            pre_r <= pre_r + 32'd1;
         end
      end else if (state_r == IDLE) begin
         pre_r <= 32'd0;
      end else begin
         pre_r <= pre_r;
      end
   end

   // BCD digit counter and rollover pulse; >=9 tests keep the digits inside 0..9
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         d0_r   <= 4'd0;
         d1_r   <= 4'd0;
         wrap_r <= 1'b0;
      end else if (bus.CLEAR) begin
         d0_r   <= 4'd0;
         d1_r   <= 4'd0;
         wrap_r <= 1'b0;
      end else if (tick_s) begin
         wrap_r <= (d1_r >= 4'd9) && (d0_r >= 4'd9);
         if (d0_r >= 4'd9) begin
            d0_r <= 4'd0;
            if (d1_r >= 4'd9) begin
               d1_r <= 4'd0;
            end else begin
               d1_r <= d1_r + 4'd1;
            end
         end else begin
            d0_r <= d0_r + 4'd1;
         end
      end else begin
         wrap_r <= 1'b0;
      end
   end

`ifdef LAP_HOLD_EN
   logic       lap_meta_r;
   logic       lap_sync_r;
   logic       lap_hold_r;
   logic [3:0] snap0_r;
   logic [3:0] snap1_r;

   // Lap synchronizer and snapshot taken on the first synced-high cycle
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         lap_meta_r <= 1'b0;
         lap_sync_r <= 1'b0;
         lap_hold_r <= 1'b0;
         snap0_r    <= 4'd0;
         snap1_r    <= 4'd0;
      end else begin
         lap_meta_r <= bus.LAP;
         lap_sync_r <= lap_meta_r;
         lap_hold_r <= lap_sync_r;
         if (bus.CLEAR) begin
            snap0_r <= 4'd0;
            snap1_r <= 4'd0;
         end else if (lap_sync_r && !lap_hold_r) begin
            snap0_r <= d0_r;
            snap1_r <= d1_r;
         end else begin
            snap0_r <= snap0_r;
            snap1_r <= snap1_r;
         end
      end
   end

   assign bus.DIGIT0 = lap_hold_r ? snap0_r : d0_r;
   assign bus.DIGIT1 = lap_hold_r ? snap1_r : d1_r;
`else
   assign bus.DIGIT0 = d0_r;
   assign bus.DIGIT1 = d1_r;
`endif

   assign bus.RUNNING = running_r;
   assign bus.WRAP    = wrap_r;

endmodule

// File: doc/bcd_stopwatch_counter.md
BCD_STOPWATCH_COUNTER -- requirements
Module: bcd_stopwatch_counter

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 50000000, meaning CLOCK_50 cycles per count increment (legal range 2..2^32-1).
REQ-002 The block SHALL have port CLOCK_50, input, 1 bit, the single system clock, with all state on its rising edge.
REQ-003 The block SHALL have port RESET, input, 1 bit, asynchronous active-high reset.
REQ-004 The block SHALL have port START_STOP, input, 1 bit, asynchronous level from a switch or button; each rising edge is one command.
REQ-005 The block SHALL have port CLEAR, input, 1 bit, synchronous active-high clear, sampled directly.
REQ-006 The block SHALL have port DIGIT0, output, 4 bits, ones digit in BCD (0..9), fed to a seven-segment decoder.
REQ-007 The block SHALL have port DIGIT1, output, 4 bits, tens digit in BCD (0..9), fed to a seven-segment decoder.
REQ-008 The block SHALL have port RUNNING, output, 1 bit, high while in state RUN.
REQ-009 The block SHALL have port WRAP, output, 1 bit, one-cycle pulse on the 99->00 rollover.

Function
REQ-010 START_STOP SHALL pass through a 2-flop synchronizer, then a previous-value register; the command is sync2 & ~prev.
REQ-011 A START_STOP rise SHALL take effect on state at the 3rd rising CLOCK_50 edge after it is first sampled.
REQ-012 The FSM SHALL have states IDLE, RUN and PAUSE, with RUNNING = (state == RUN), all registered.
REQ-013 On a command, IDLE SHALL go to RUN, RUN SHALL go to PAUSE, and PAUSE SHALL go to RUN; without a command, state SHALL hold.
REQ-014 From any state, CLEAR SHALL force IDLE, zero the digits and zero the prescaler, and SHALL win over a same-cycle command or tick.
REQ-015 The prescaler SHALL be 32 bits and SHALL count only in RUN.
REQ-016 The prescaler SHALL hold its value in PAUSE and SHALL be 0 in IDLE.
REQ-017 A tick SHALL occur when the prescaler equals TICK_DIV-1 in RUN; on that edge the prescaler SHALL return to 0.
REQ-018 The first increment SHALL land exactly TICK_DIV cycles after RUN is entered from IDLE.
REQ-019 On a tick, DIGIT0 SHALL increment; at 9 it SHALL go to 0 and DIGIT1 SHALL increment; at 99 both SHALL become 0.
REQ-020 The block SHALL never output digit values 10..15.
REQ-021 WRAP SHALL be registered, SHALL be high for exactly the cycle in which the digits first read 00 after 99, and SHALL be low otherwise.
REQ-022 A command arriving on a tick edge SHALL apply both: the increment happens, and the state changes to PAUSE.
REQ-023 A tick SHALL NOT be lost or repeated across PAUSE/RUN transitions; pause time SHALL not advance the count.

Reset
REQ-024 RESET high SHALL immediately force, without waiting for a clock edge: state IDLE, DIGIT0=0, DIGIT1=0, RUNNING=0, WRAP=0, prescaler=0, and all synchronizer/edge flops=0.
REQ-025 Because the synchronizer flops reset to 0, a START_STOP held high through RESET release SHALL produce one command 3 edges later.
REQ-026 RESET asserted mid-count SHALL discard all progress; after release the block SHALL behave as after power-up.

Configuration
REQ-027 Macro LAP_HOLD_EN, when defined, SHALL add port LAP, input, 1 bit, synchronized by 2 flops.
REQ-028 With LAP_HOLD_EN defined, while synced LAP=1, DIGIT0/DIGIT1 SHALL show a snapshot captured on the first cycle synced LAP=1 and the internal count SHALL continue.
REQ-029 With LAP_HOLD_EN defined, on synced LAP=0 the outputs SHALL show the live count next cycle; CLEAR SHALL also clear the snapshot; WRAP SHALL follow the live count.
REQ-030 Without LAP_HOLD_EN, the LAP port and snapshot logic SHALL be absent and the digits SHALL always be live.

Verification (TICK_DIV=4)
REQ-031 RESET pulse mid-RUN at count 37 -> DIGIT1=0, DIGIT0=0, RUNNING=0 asynchronously.
REQ-032 START_STOP rise from IDLE -> RUNNING=1 at the 3rd edge; DIGIT0=1 at 4 cycles after that; after 40 cycles DIGIT1=1, DIGIT0=0.
REQ-033 Run to 99, one more tick -> digits 00 with WRAP=1 for exactly 1 cycle; the next tick -> 01 with WRAP=0.
REQ-034 Pause at prescaler=2, wait 100 cycles, resume -> no change during the pause; the next increment lands 2 cycles after RUN is re-entered.
REQ-035 CLEAR and a START_STOP command in the same cycle while in RUN at count 55 -> state IDLE, 00, RUNNING=0.
REQ-036 With LAP_HOLD_EN, LAP high at count 12 for 20 ticks -> outputs hold 12; LAP low -> outputs show 32 the next cycle.
